// File: rtl/prefetch_sequencer_pkg.sv
// Shared types, default parameters and helpers for the prefetch sequencer.
package prefetch_sequencer_pkg;

    typedef enum logic {
        PF_RUN    = 1'b0,
        PF_HALTED = 1'b1
    } pf_state_e;

    localparam int PF_ADDR_BITS    = 16;
    localparam int PF_DATA_BITS    = 16;
    localparam int PF_DEPTH        = 3;
    localparam int PF_MAX_INFLIGHT = 2;
    localparam int PF_RESET_ADDR   = 0;

    // Bits needed to hold the values 0..max_value inclusive.
    function automatic int cnt_bits(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/prefetch_sequencer_if.sv
// Bundle of the decoder, memory-port and FIFO-control signals around the sequencer.
interface prefetch_sequencer_if
    import prefetch_sequencer_pkg::*;
#(
    parameter int ADDR_BITS = PF_ADDR_BITS,
    parameter int DATA_BITS = PF_DATA_BITS
);
    // redirect / flow control from the decoder side
    logic                 jump;
    logic [ADDR_BITS-1:0] jump_addr;
    logic                 halt;
    logic                 consume;
    // memory request/response port
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_BITS-1:0] req_addr;
    logic                 resp_valid;
    logic [DATA_BITS-1:0] resp_data;
    // prefetch FIFO control
    logic                 fifo_add;
    logic [DATA_BITS-1:0] fifo_entry;
    logic                 fifo_flush;
    logic                 fifo_nonempty;
    logic [ADDR_BITS-1:0] head_addr;

    // sequencer side
    modport master (
        input  jump, jump_addr, halt, consume, req_ready, resp_valid, resp_data,
        output req_valid, req_addr, fifo_add, fifo_entry, fifo_flush,
               fifo_nonempty, head_addr
    );

    // memory / decoder / FIFO side
    modport slave (
        output jump, jump_addr, halt, consume, req_ready, resp_valid, resp_data,
        input  req_valid, req_addr, fifo_add, fifo_entry, fifo_flush,
               fifo_nonempty, head_addr
    );

endinterface

// File: rtl/prefetch_sequencer_counter.sv
// Saturation-free up/down counter with load priority; exposes current and next value.
module updown_counter #(
    parameter int BITS = 2,
    parameter int MAX  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc_i,
    input  logic            dec_i,
    input  logic            load_i,
    input  logic [BITS-1:0] load_value_i,
    output logic [BITS-1:0] count_o,
    output logic [BITS-1:0] count_next_o
);

    localparam logic [BITS-1:0] ONE   = BITS'(1);
    localparam logic [BITS-1:0] MAX_V = BITS'(MAX);

    logic [BITS-1:0] count_q;
    logic [BITS-1:0] count_d;

    // next value: load wins, simultaneous inc and dec cancel
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (inc_i && !dec_i) begin
            count_d = count_q + ONE;
        end else if (dec_i && !inc_i) begin
            count_d = count_q - ONE;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

    a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= MAX_V);

endmodule

// File: rtl/prefetch_sequencer.sv
// Fetches sequential instruction words into the prefetch FIFO, bounding
// FIFO occupancy plus live in-flight requests by the FIFO depth, and
// discarding responses that belong to a stream abandoned by a jump.
//
// state      | meaning
// PF_RUN     | requests may be issued
// PF_HALTED  | no new requests; responses and consumes still processed
module prefetch_sequencer
    import prefetch_sequencer_pkg::*;
#(
    parameter int ADDR_BITS    = PF_ADDR_BITS,
    parameter int DATA_BITS    = PF_DATA_BITS,
    parameter int DEPTH        = PF_DEPTH,
    parameter int MAX_INFLIGHT = PF_MAX_INFLIGHT,
    parameter int RESET_ADDR   = PF_RESET_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    prefetch_sequencer_if.master bus
);

    localparam int OCC_W = cnt_bits(DEPTH);
    localparam int INF_W = cnt_bits(MAX_INFLIGHT);

    localparam logic [ADDR_BITS-1:0] RESET_ADDR_V = ADDR_BITS'(RESET_ADDR);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE     = ADDR_BITS'(1);
    localparam logic [31:0]          DEPTH_V      = 32'(DEPTH);
    localparam logic [31:0]          MAX_INF_V    = 32'(MAX_INFLIGHT);

    pf_state_e state_q, state_d;

    logic                 req_valid_q, req_valid_d;
    logic [ADDR_BITS-1:0] req_addr_q,  req_addr_d;
    logic [ADDR_BITS-1:0] head_addr_q, head_addr_d;

    logic [OCC_W-1:0] occ_q,  occ_d;
    logic [INF_W-1:0] infl_q, infl_d;
    logic [INF_W-1:0] disc_q, disc_d;

    logic                 transfer;
    logic                 resp_keep;
    logic                 resp_drop;
    logic [31:0]          budget_used;
    logic                 issue_ok;
    logic [DATA_BITS-1:0] resp_word;

    assign transfer  = req_valid_q & bus.req_ready;
    // a response is kept only when it belongs to the current stream
    assign resp_drop = bus.resp_valid & (disc_q != '0);
    assign resp_keep = bus.resp_valid & ~bus.jump & (disc_q == '0);

    updown_counter #(.BITS(OCC_W), .MAX(DEPTH)) u_occ (
        .clk          (clk),
        .reset        (reset),
        .inc_i        (resp_keep),
        .dec_i        (bus.consume),
        .load_i       (bus.jump),
        .load_value_i ('0),
        .count_o      (occ_q),
        .count_next_o (occ_d)
    );

    updown_counter #(.BITS(INF_W), .MAX(MAX_INFLIGHT)) u_infl (
        .clk          (clk),
        .reset        (reset),
        .inc_i        (transfer),
        .dec_i        (bus.resp_valid),
        .load_i       (1'b0),
        .load_value_i ('0),
        .count_o      (infl_q),
        .count_next_o (infl_d)
    );

    // on jump every request still live after this cycle belongs to the old stream
    updown_counter #(.BITS(INF_W), .MAX(MAX_INFLIGHT)) u_disc (
        .clk          (clk),
        .reset        (reset),
        .inc_i        (1'b0),
        .dec_i        (resp_drop),
        .load_i       (bus.jump),
        .load_value_i (infl_d),
        .count_o      (disc_q),
        .count_next_o (disc_d)
    );

    // discarded requests will never land in the FIFO, so they do not use budget
    assign budget_used = 32'(occ_d) + 32'(infl_d) - 32'(disc_d);
    assign issue_ok    = (state_d == PF_RUN) && (32'(infl_d) < MAX_INF_V) &&
                         (budget_used < DEPTH_V);

    // state register and fetch datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PF_RUN;
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_ADDR_V;
            head_addr_q <= RESET_ADDR_V;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            head_addr_q <= head_addr_d;
        end
    end

    // next state: halt is a level that parks the sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            PF_RUN:    if (bus.halt)  state_d = PF_HALTED;
            PF_HALTED: if (!bus.halt) state_d = PF_RUN;
            default:   state_d = PF_RUN;
        endcase
    end

    // request and head-pointer next values; a raised request holds until taken
    always_comb begin
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        head_addr_d = head_addr_q;
        if (bus.jump) begin
            req_valid_d = 1'b0;
            req_addr_d  = bus.jump_addr;
            head_addr_d = bus.jump_addr;
        end else begin
            if (transfer) begin
                req_addr_d = req_addr_q + ADDR_ONE;
            end
            if (bus.consume) begin
                head_addr_d = head_addr_q + ADDR_ONE;
            end
            req_valid_d = (req_valid_q & ~transfer) | issue_ok;
        end
    end

    assign resp_word         = bus.resp_data;
    assign bus.req_valid     = req_valid_q;
    assign bus.req_addr      = req_addr_q;
    assign bus.head_addr     = head_addr_q;
    assign bus.fifo_add      = resp_keep;
    assign bus.fifo_entry    = resp_word;
    assign bus.fifo_flush    = reset | bus.jump;
    assign bus.fifo_nonempty = (occ_q != '0);

    a_consume_empty: assert property (@(posedge clk) disable iff (reset)
        !(bus.consume && (occ_q == '0)));
    a_resp_idle: assert property (@(posedge clk) disable iff (reset)
        !(bus.resp_valid && (infl_q == '0)));
    a_discard_bound: assert property (@(posedge clk) disable iff (reset)
        disc_q <= infl_q);

endmodule

// File: tb/tb_prefetch_sequencer.sv
// Scenario bench for prefetch_sequencer with a 1-cycle memory model and
// a scoreboard of expected FIFO pushes.
module tb_prefetch_sequencer;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 3;
    localparam int MAXI  = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    prefetch_sequencer_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

    prefetch_sequencer #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .DEPTH(DEPTH),
        .MAX_INFLIGHT(MAXI), .RESET_ADDR(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [AW-1:0] mem_addr_q[$];
    bit            mem_stale_q[$];
    logic [DW-1:0] sb[$];
    logic [AW-1:0] fifo_m[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;
    int n_drops  = 0;
    bit mem_en   = 1'b1;
    bit prev_hold = 1'b0;
    bit last_xfer = 1'b0;
    bit last_resp = 1'b0;
    logic [AW-1:0] req_addr_m = '0;
    logic [AW-1:0] head_m     = '0;
    logic [AW-1:0] last_xfer_addr = '0;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // one clock cycle with the inputs the caller has set up
    task automatic step();
        bit            stale;
        bit            xfer;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp;
        stale = 1'b0;
        raddr = '0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        if (mem_en && mem_addr_q.size() > 0) begin
            raddr = mem_addr_q.pop_front();
            stale = mem_stale_q.pop_front() || bus.jump;
            bus.resp_valid = 1'b1;
            bus.resp_data  = data_of(raddr);
            if (!stale) sb.push_back(data_of(raddr));
        end
        if (bus.consume && fifo_m.size() == 0) bus.consume = 1'b0;
        @(negedge clk);
        xfer = bus.req_valid & bus.req_ready;
        n_checks++;
        if (bus.fifo_flush !== bus.jump) begin
            n_errors++;
            $display("FAIL flush: got %0b expected %0b", bus.fifo_flush, bus.jump);
        end
        if (prev_hold) begin
            n_checks++;
            if (bus.req_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL req_hold: req_valid got %0b expected 1", bus.req_valid);
            end
        end
        if (bus.req_valid) begin
            n_checks++;
            if (bus.req_addr !== req_addr_m) begin
                n_errors++;
                $display("FAIL req_addr: got %0h expected %0h", bus.req_addr, req_addr_m);
            end
        end
        n_checks++;
        if (bus.head_addr !== head_m) begin
            n_errors++;
            $display("FAIL head_addr: got %0h expected %0h", bus.head_addr, head_m);
        end
        n_checks++;
        if (bus.fifo_nonempty !== (fifo_m.size() != 0)) begin
            n_errors++;
            $display("FAIL nonempty: got %0b expected %0b", bus.fifo_nonempty, fifo_m.size() != 0);
        end
        n_checks++;
        if (bus.resp_valid && stale) begin
            n_drops++;
            if (bus.fifo_add !== 1'b0) begin
                n_errors++;
                $display("FAIL drop: fifo_add got %0b expected 0 (addr %0h)", bus.fifo_add, raddr);
            end
        end else if (bus.resp_valid) begin
            if (bus.fifo_add !== 1'b1) begin
                n_errors++;
                $display("FAIL push: fifo_add got %0b expected 1 (addr %0h)", bus.fifo_add, raddr);
            end
            exp = sb.pop_front();
            n_checks++;
            if (bus.fifo_entry !== exp) begin
                n_errors++;
                $display("FAIL entry: got %0h expected %0h", bus.fifo_entry, exp);
            end
        end else if (bus.fifo_add !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_add: fifo_add got %0b expected 0", bus.fifo_add);
        end
        prev_hold = bus.req_valid && !bus.req_ready && !bus.jump;
        last_xfer = xfer;
        last_resp = bus.resp_valid;
        if (bus.jump) begin
            foreach (mem_stale_q[i]) mem_stale_q[i] = 1'b1;
        end
        if (xfer) begin
            n_xfer++;
            last_xfer_addr = req_addr_m;
            mem_addr_q.push_back(req_addr_m);
            mem_stale_q.push_back(bus.jump);
        end
        if (bus.jump) begin
            fifo_m.delete();
            head_m     = bus.jump_addr;
            req_addr_m = bus.jump_addr;
        end else begin
            if (xfer) req_addr_m = req_addr_m + 16'd1;
            if (bus.resp_valid && !stale) fifo_m.push_back(raddr);
            if (bus.consume) begin
                void'(fifo_m.pop_front());
                head_m = head_m + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        bus.jump    = 1'b0;
        bus.consume = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.jump       = 1'b0;
        bus.jump_addr  = '0;
        bus.halt       = 1'b0;
        bus.consume    = 1'b0;
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 5;
        if (bus.req_valid !== 1'b0) begin
            n_errors++; $display("FAIL rst_req_valid: got %0b expected 0", bus.req_valid);
        end
        if (bus.fifo_flush !== 1'b1) begin
            n_errors++; $display("FAIL rst_flush: got %0b expected 1", bus.fifo_flush);
        end
        if (bus.fifo_add !== 1'b0) begin
            n_errors++; $display("FAIL rst_fifo_add: got %0b expected 0", bus.fifo_add);
        end
        if (bus.req_addr !== 16'h0 || bus.head_addr !== 16'h0) begin
            n_errors++; $display("FAIL rst_addr: req %0h head %0h expected 0 0", bus.req_addr, bus.head_addr);
        end
        if (bus.fifo_nonempty !== 1'b0) begin
            n_errors++; $display("FAIL rst_nonempty: got %0b expected 0", bus.fifo_nonempty);
        end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        int x0;
        x0 = n_xfer;
        mem_en = 1'b1;
        bus.req_ready = 1'b1;
        repeat (12) step();
        n_checks += 3;
        if (n_xfer - x0 != 3) begin
            n_errors++; $display("FAIL fill_count: got %0d requests expected 3", n_xfer - x0);
        end
        if (fifo_m.size() != 3) begin
            n_errors++; $display("FAIL fill_occ: got %0d entries expected 3", fifo_m.size());
        end
        if (bus.req_valid !== 1'b0) begin
            n_errors++; $display("FAIL fill_stall: req_valid got %0b expected 0", bus.req_valid);
        end
    endtask

    task automatic test_consume_refill();
        int x0;
        x0 = n_xfer;
        bus.consume = 1'b1;
        step();
        repeat (8) step();
        n_checks += 3;
        if (n_xfer - x0 != 1) begin
            n_errors++; $display("FAIL refill_count: got %0d requests expected 1", n_xfer - x0);
        end
        if (last_xfer_addr !== 16'h0003) begin
            n_errors++; $display("FAIL refill_addr: got %0h expected 3", last_xfer_addr);
        end
        if (bus.head_addr !== 16'h0001) begin
            n_errors++; $display("FAIL refill_head: got %0h expected 1", bus.head_addr);
        end
    endtask

    task automatic test_jump_inflight();
        int d0;
        logic [AW-1:0] front;
        mem_en = 1'b0;
        repeat (3) begin
            bus.consume = 1'b1;
            step();
        end
        n_checks++;
        if (mem_addr_q.size() != 2) begin
            n_errors++; $display("FAIL jump_inflight: got %0d in flight expected 2", mem_addr_q.size());
        end
        d0 = n_drops;
        bus.jump      = 1'b1;
        bus.jump_addr = 16'h0100;
        step();
        mem_en = 1'b1;
        repeat (10) step();
        front = (fifo_m.size() > 0) ? fifo_m[0] : 16'hDEAD;
        n_checks += 3;
        if (n_drops - d0 != 2) begin
            n_errors++; $display("FAIL jump_drops: got %0d dropped expected 2", n_drops - d0);
        end
        if (front !== 16'h0100) begin
            n_errors++; $display("FAIL jump_first: got %0h expected 100", front);
        end
        if (bus.head_addr !== 16'h0100) begin
            n_errors++; $display("FAIL jump_head: got %0h expected 100", bus.head_addr);
        end
    endtask

    task automatic test_jump_xfer_resp();
        int d0;
        logic [AW-1:0] front;
        bus.consume = 1'b1;
        step();
        bus.consume = 1'b1;
        step();
        d0 = n_drops;
        bus.jump      = 1'b1;
        bus.jump_addr = 16'h2000;
        step();
        n_checks += 3;
        if (!(last_xfer && last_resp)) begin
            n_errors++; $display("FAIL coincide: xfer %0b resp %0b expected 1 1", last_xfer, last_resp);
        end
        if (bus.req_addr !== 16'h2000) begin
            n_errors++; $display("FAIL coincide_addr: got %0h expected 2000", bus.req_addr);
        end
        if (bus.req_valid !== 1'b0) begin
            n_errors++; $display("FAIL coincide_valid: got %0b expected 0", bus.req_valid);
        end
        repeat (10) step();
        front = (fifo_m.size() > 0) ? fifo_m[0] : 16'hDEAD;
        n_checks += 2;
        if (n_drops - d0 != 2) begin
            n_errors++; $display("FAIL coincide_drops: got %0d expected 2", n_drops - d0);
        end
        if (front !== 16'h2000) begin
            n_errors++; $display("FAIL coincide_first: got %0h expected 2000", front);
        end
    endtask

    task automatic test_ready_stall_halt();
        logic [AW-1:0] a0;
        int x0;
        int f0;
        bus.req_ready = 1'b0;
        bus.consume   = 1'b1;
        step();
        a0 = bus.req_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus.req_valid !== 1'b1 || bus.req_addr !== a0) begin
                n_errors++;
                $display("FAIL stall_stable: valid %0b addr %0h expected 1 %0h", bus.req_valid, bus.req_addr, a0);
            end
        end
        bus.req_ready = 1'b1;
        repeat (6) step();
        mem_en = 1'b0;
        repeat (3) begin
            bus.consume = 1'b1;
            step();
        end
        n_checks++;
        if (mem_addr_q.size() != 2) begin
            n_errors++; $display("FAIL halt_inflight: got %0d expected 2", mem_addr_q.size());
        end
        bus.halt = 1'b1;
        mem_en   = 1'b1;
        x0 = n_xfer;
        f0 = fifo_m.size();
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (bus.req_valid !== 1'b0) begin
                n_errors++; $display("FAIL halt_noreq: req_valid got %0b expected 0", bus.req_valid);
            end
        end
        n_checks += 2;
        if (n_xfer != x0) begin
            n_errors++; $display("FAIL halt_xfer: got %0d requests expected 0", n_xfer - x0);
        end
        if (fifo_m.size() != f0 + 2) begin
            n_errors++; $display("FAIL halt_push: got %0d entries expected %0d", fifo_m.size(), f0 + 2);
        end
        bus.halt = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] e0;
        logic [AW-1:0] e1;
        bus.jump      = 1'b1;
        bus.jump_addr = 16'hFFFF;
        step();
        repeat (10) step();
        e0 = (fifo_m.size() > 1) ? fifo_m[0] : 16'hDEAD;
        e1 = (fifo_m.size() > 1) ? fifo_m[1] : 16'hDEAD;
        n_checks += 2;
        if (e0 !== 16'hFFFF || e1 !== 16'h0000) begin
            n_errors++; $display("FAIL wrap_req: got %0h %0h expected ffff 0", e0, e1);
        end
        if (bus.head_addr !== 16'hFFFF) begin
            n_errors++; $display("FAIL wrap_head0: got %0h expected ffff", bus.head_addr);
        end
        bus.consume = 1'b1;
        step();
        n_checks++;
        if (bus.head_addr !== 16'h0000) begin
            n_errors++; $display("FAIL wrap_head1: got %0h expected 0", bus.head_addr);
        end
        bus.consume = 1'b1;
        step();
        n_checks++;
        if (bus.head_addr !== 16'h0001) begin
            n_errors++; $display("FAIL wrap_head2: got %0h expected 1", bus.head_addr);
        end
        repeat (6) step();
        n_checks += 2;
        if (sb.size() != 0) begin
            n_errors++; $display("FAIL sb_drain: %0d expected pushes left", sb.size());
        end
        if (fifo_m.size() > DEPTH) begin
            n_errors++; $display("FAIL overflow: %0d entries exceed %0d", fifo_m.size(), DEPTH);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_consume_refill();
        test_jump_inflight();
        test_jump_xfer_resp();
        test_ready_stall_halt();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
